// File: rtl/br_lite_local_ni.sv
// BrLite local network interface: PE-side valid/ready streams to and from the
// router LOCAL port. Flits cross the router boundary with a 4-phase req/ack handshake.
package br_lite_pkg;
  localparam int BR_ID_W = 3;

  typedef enum logic [1:0] {
    BR_SVC_ALL   = 2'd0,
    BR_SVC_TGT   = 2'd1,
    BR_SVC_CLEAR = 2'd2,
    BR_SVC_MON   = 2'd3
  } br_svc_t;

  typedef struct packed {
    br_svc_t              service;
    logic [15:0]          source;
    logic [15:0]          target;
    logic [BR_ID_W-1:0]   id;
    logic [31:0]          payload;
  } br_data_t;
endpackage

module br_lite_local_ni
  import br_lite_pkg::*;
#(
  parameter logic [15:0] ADDRESS  = 16'h0,
  parameter int          TX_DEPTH = 4,
  parameter int          RX_DEPTH = 4
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     tx_valid_i,
  output logic     tx_ready_o,
  input  br_data_t tx_data_i,
  output logic     tx_err_o,
  output logic     rx_valid_o,
  input  logic     rx_ready_i,
  output br_data_t rx_data_o,
  output br_data_t br_flit_o,
  output logic     br_req_o,
  input  logic     br_ack_i,
  input  br_data_t br_flit_i,
  input  logic     br_req_i,
  output logic     br_ack_o,
  input  logic     br_local_busy_i
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);

  typedef enum logic [1:0] {TX_IDLE, TX_REQ, TX_WAIT_ACK_LOW} tx_state_t;
  typedef enum logic {RX_IDLE, RX_ACK} rx_state_t;

  br_data_t             r_txMem [TX_DEPTH];
  logic [TX_AW:0]       r_txWr;
  logic [TX_AW:0]       r_txRd;
  logic                 r_txReady;
  logic                 r_txErr;
  tx_state_t            r_txState;
  tx_state_t            w_txStateNext;
  br_data_t             r_flit;
  logic [BR_ID_W-1:0]   r_idCnt;
  logic                 w_txSvcOk;
  logic                 w_txHs;
  logic                 w_txPush;
  logic                 w_txPop;
  logic                 w_txLoad;
  logic                 w_txEmpty;
  logic [TX_AW:0]       w_txWrNext;
  logic [TX_AW:0]       w_txRdNext;
  logic                 w_txFullNext;
  br_data_t             w_txStamped;

  br_data_t             r_rxMem [RX_DEPTH];
  logic [RX_AW:0]       r_rxWr;
  logic [RX_AW:0]       r_rxRd;
  rx_state_t            r_rxState;
  rx_state_t            w_rxStateNext;
  logic                 w_rxPush;
  logic                 w_rxPop;
  logic                 w_rxEmpty;
  logic                 w_rxFull;

  assign w_txSvcOk  = (tx_data_i.service == BR_SVC_ALL) || (tx_data_i.service == BR_SVC_TGT);
  assign w_txHs     = tx_valid_i && r_txReady;
  assign w_txPush   = w_txHs && w_txSvcOk;
  assign w_txEmpty  = (r_txWr == r_txRd);
  assign w_txWrNext = r_txWr + {{TX_AW{1'b0}}, w_txPush};
  assign w_txRdNext = r_txRd + {{TX_AW{1'b0}}, w_txPop};
  // Ready is computed from the post-edge pointers so it never passes through on a full FIFO.
  assign w_txFullNext = (w_txWrNext[TX_AW] != w_txRdNext[TX_AW]) &&
                        (w_txWrNext[TX_AW-1:0] == w_txRdNext[TX_AW-1:0]);

  assign tx_ready_o = r_txReady;
  assign tx_err_o   = r_txErr;
  assign br_flit_o  = r_flit;
  assign br_req_o   = (r_txState == TX_REQ);

  always_ff @(posedge clk_i) begin
    if (w_txPush) r_txMem[r_txWr[TX_AW-1:0]] <= tx_data_i;
  end

  always_comb begin
    w_txStamped        = r_txMem[r_txRd[TX_AW-1:0]];
    w_txStamped.source = ADDRESS;
    w_txStamped.id     = r_idCnt;
  end

  always_comb begin
    w_txStateNext = r_txState;
    w_txPop       = 1'b0;
    w_txLoad      = 1'b0;
    case (r_txState)
      TX_IDLE: begin
        if (!w_txEmpty && !br_local_busy_i) begin
          w_txLoad      = 1'b1;
          w_txStateNext = TX_REQ;
        end
      end
      TX_REQ: begin
        if (br_ack_i) begin
          w_txPop       = 1'b1;
          w_txStateNext = TX_WAIT_ACK_LOW;
        end
      end
      TX_WAIT_ACK_LOW: begin
        if (!br_ack_i) w_txStateNext = TX_IDLE;
      end
      default: w_txStateNext = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_txWr    <= '0;
      r_txRd    <= '0;
      r_txReady <= 1'b1;
      r_txErr   <= 1'b0;
      r_txState <= TX_IDLE;
      r_flit    <= '0;
      r_idCnt   <= '0;
    end else begin
      r_txWr    <= w_txWrNext;
      r_txRd    <= w_txRdNext;
      r_txReady <= !w_txFullNext;
      r_txErr   <= w_txHs && !w_txSvcOk;
      r_txState <= w_txStateNext;
      if (w_txLoad) r_flit <= w_txStamped;
      if (w_txPop)  r_idCnt <= r_idCnt + BR_ID_W'(1);
    end
  end

  assign w_rxEmpty  = (r_rxWr == r_rxRd);
  assign w_rxFull   = (r_rxWr[RX_AW] != r_rxRd[RX_AW]) &&
                      (r_rxWr[RX_AW-1:0] == r_rxRd[RX_AW-1:0]);
  assign w_rxPop    = rx_ready_i && !w_rxEmpty;
  assign rx_valid_o = !w_rxEmpty;
  assign rx_data_o  = r_rxMem[r_rxRd[RX_AW-1:0]];
  assign br_ack_o   = (r_rxState == RX_ACK);

  always_ff @(posedge clk_i) begin
    if (w_rxPush) r_rxMem[r_rxWr[RX_AW-1:0]] <= br_flit_i;
  end

  // A flit is captured only on the IDLE->ACK transition, so a long req still pushes once.
  always_comb begin
    w_rxStateNext = r_rxState;
    w_rxPush      = 1'b0;
    case (r_rxState)
      RX_IDLE: begin
        if (br_req_i && !w_rxFull) begin
          w_rxPush      = 1'b1;
          w_rxStateNext = RX_ACK;
        end
      end
      RX_ACK: begin
        if (!br_req_i) w_rxStateNext = RX_IDLE;
      end
      default: w_rxStateNext = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rxWr    <= '0;
      r_rxRd    <= '0;
      r_rxState <= RX_IDLE;
    end else begin
      r_rxWr    <= r_rxWr + {{RX_AW{1'b0}}, w_rxPush};
      r_rxRd    <= r_rxRd + {{RX_AW{1'b0}}, w_rxPop};
      r_rxState <= w_rxStateNext;
    end
  end

endmodule

// File: tb/tb_br_lite_local_ni.sv
// Scoreboard bench for br_lite_local_ni: a router model acks injections,
// monitors pop expected flits from queues on TX req rise and on RX pops.
module tb_br_lite_local_ni;
  import br_lite_pkg::*;

  localparam logic [15:0] ADDR = 16'h0001;
  localparam int          DW   = $bits(br_data_t);

  logic     clk_i;
  logic     rst_ni;
  logic     tx_valid_i;
  logic     tx_ready_o;
  br_data_t tx_data_i;
  logic     tx_err_o;
  logic     rx_valid_o;
  logic     rx_ready_i;
  br_data_t rx_data_o;
  br_data_t br_flit_o;
  logic     br_req_o;
  logic     br_ack_i;
  br_data_t br_flit_i;
  logic     br_req_i;
  logic     br_ack_o;
  logic     br_local_busy_i;

  br_lite_local_ni #(.ADDRESS(ADDR), .TX_DEPTH(4), .RX_DEPTH(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o), .tx_data_i(tx_data_i), .tx_err_o(tx_err_o),
    .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i), .rx_data_o(rx_data_o),
    .br_flit_o(br_flit_o), .br_req_o(br_req_o), .br_ack_i(br_ack_i),
    .br_flit_i(br_flit_i), .br_req_i(br_req_i), .br_ack_o(br_ack_o),
    .br_local_busy_i(br_local_busy_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int                 nChecks = 0;
  int                 nFails  = 0;
  br_data_t           txExp[$];
  br_data_t           rxExp[$];
  logic [BR_ID_W-1:0] expId = '0;
  bit                 ackEnable = 1'b1;
  int                 ackDelay = 1;
  int                 lastReqLen = 0;

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  function automatic br_data_t mkMsg(br_svc_t svc, logic [15:0] tgt, logic [31:0] pl);
    br_data_t m;
    m.service = svc;
    m.source  = 16'hBEEF;
    m.target  = tgt;
    m.id      = '1;
    m.payload = pl;
    return m;
  endfunction

  // Router side of the TX handshake: ack after ackDelay cycles of req, drop when req drops.
  initial begin
    int cnt;
    cnt = 0;
    br_ack_i = 1'b0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        br_ack_i = 1'b0;
        cnt = 0;
      end else if (br_req_o && !br_ack_i) begin
        cnt++;
        if (ackEnable && cnt >= ackDelay) br_ack_i = 1'b1;
      end else if (!br_req_o && br_ack_i) begin
        br_ack_i = 1'b0;
        cnt = 0;
      end
    end
  end

  // TX monitor: each new request must match the oldest expected injection.
  initial begin
    logic prevReq;
    int   len;
    br_data_t e;
    prevReq = 1'b0;
    len = 0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        prevReq = 1'b0;
        len = 0;
      end else begin
        if (br_req_o && !prevReq) begin
          checkOutput("tx_req_expected", DW'(txExp.size() != 0), DW'(1));
          if (txExp.size() != 0) begin
            e = txExp.pop_front();
            checkOutput("tx_flit", br_flit_o, e);
          end
          len = 1;
        end else if (br_req_o && prevReq) begin
          len++;
        end else if (!br_req_o && prevReq) begin
          lastReqLen = len;
        end
        prevReq = br_req_o;
      end
    end
  end

  // RX monitor: every PE pop must deliver the oldest flit the router sent.
  initial begin
    br_data_t e;
    forever begin
      @(negedge clk_i);
      if (rst_ni && rx_valid_o && rx_ready_i) begin
        checkOutput("rx_pop_expected", DW'(rxExp.size() != 0), DW'(1));
        if (rxExp.size() != 0) begin
          e = rxExp.pop_front();
          checkOutput("rx_data", rx_data_o, e);
        end
      end
    end
  end

  task automatic doReset();
    rst_ni = 1'b0;
    tick();
    txExp.delete();
    rxExp.delete();
    expId = '0;
    tick();
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic applyStimulus(input br_data_t msg);
    br_data_t e;
    bit done;
    done = 1'b0;
    tx_valid_i = 1'b1;
    tx_data_i  = msg;
    for (int i = 0; i < 40 && !done; i++) begin
      if (tx_ready_o) begin
        if (msg.service == BR_SVC_ALL || msg.service == BR_SVC_TGT) begin
          e = msg;
          e.source = ADDR;
          e.id = expId;
          txExp.push_back(e);
          expId = expId + 1'b1;
        end
        done = 1'b1;
      end
      tick();
    end
    tx_valid_i = 1'b0;
    if (!done) checkOutput("tx_ready_wait", DW'(tx_ready_o), DW'(1));
  endtask

  task automatic waitTxIdle();
    for (int i = 0; i < 200; i++) begin
      if (txExp.size() == 0 && !br_req_o && !br_ack_i) break;
      tick();
    end
    checkOutput("tx_drain", DW'(txExp.size()), DW'(0));
    tick();
    tick();
  endtask

  task automatic waitReq();
    for (int i = 0; i < 40 && !br_req_o; i++) tick();
    checkOutput("tx_req_rise", DW'(br_req_o), DW'(1));
  endtask

  task automatic routerSend(input br_data_t f);
    br_flit_i = f;
    br_req_i  = 1'b1;
    rxExp.push_back(f);
    for (int i = 0; i < 40 && !br_ack_o; i++) tick();
    checkOutput("rx_ack_rise", DW'(br_ack_o), DW'(1));
    br_req_i = 1'b0;
    for (int i = 0; i < 40 && br_ack_o; i++) tick();
    checkOutput("rx_ack_fall", DW'(br_ack_o), DW'(0));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    br_data_t f;
    rst_ni = 1'b0;
    tx_valid_i = 1'b0;
    tx_data_i = '0;
    rx_ready_i = 1'b0;
    br_flit_i = '0;
    br_req_i = 1'b0;
    br_local_busy_i = 1'b0;
    tick();
    tick();
    checkOutput("rst_tx_ready", DW'(tx_ready_o), DW'(1));
    checkOutput("rst_tx_err", DW'(tx_err_o), DW'(0));
    checkOutput("rst_rx_valid", DW'(rx_valid_o), DW'(0));
    checkOutput("rst_br_req", DW'(br_req_o), DW'(0));
    checkOutput("rst_br_ack", DW'(br_ack_o), DW'(0));
    rst_ni = 1'b1;
    tick();

    $display("[TB] reset during TX_REQ");
    ackEnable = 1'b0;
    applyStimulus(mkMsg(BR_SVC_ALL, 16'h0005, 32'h1111_0000));
    waitReq();
    tick();
    tick();
    #1 rst_ni = 1'b0;
    #1;
    checkOutput("midreq_rst_req", DW'(br_req_o), DW'(0));
    checkOutput("midreq_rst_ready", DW'(tx_ready_o), DW'(1));
    txExp.delete();
    expId = '0;
    tick();
    rst_ni = 1'b1;
    ackEnable = 1'b1;
    ackDelay = 1;
    tick();
    applyStimulus(mkMsg(BR_SVC_TGT, 16'h0007, 32'h2222_0000));
    waitTxIdle();

    $display("[TB] TGT injection with 3-cycle ack");
    doReset();
    ackDelay = 3;
    applyStimulus(mkMsg(BR_SVC_TGT, 16'h0102, 32'h0000_CAFE));
    checkOutput("tx_err_good", DW'(tx_err_o), DW'(0));
    applyStimulus(mkMsg(BR_SVC_ALL, 16'h0304, 32'h0000_BEEF));
    waitTxIdle();
    checkOutput("req_high_len", DW'(lastReqLen), DW'(3));

    $display("[TB] local busy throttle and id wrap");
    ackDelay = 1;
    for (int i = 0; i < 5; i++) applyStimulus(mkMsg(BR_SVC_TGT, 16'h0010 + 16'(i), 32'h3000 + 32'(i)));
    waitTxIdle();
    br_local_busy_i = 1'b1;
    applyStimulus(mkMsg(BR_SVC_TGT, 16'h0A0A, 32'hAAAA_0007));
    applyStimulus(mkMsg(BR_SVC_ALL, 16'h0B0B, 32'hBBBB_0000));
    for (int i = 0; i < 4; i++) begin
      checkOutput("busy_no_req", DW'(br_req_o), DW'(0));
      tick();
    end
    br_local_busy_i = 1'b0;
    tick();
    checkOutput("req_after_busy", DW'(br_req_o), DW'(1));
    waitTxIdle();

    $display("[TB] rejected CLEAR service");
    applyStimulus(mkMsg(BR_SVC_CLEAR, 16'h0C0C, 32'hC1EA_0000));
    checkOutput("err_pulse", DW'(tx_err_o), DW'(1));
    tick();
    checkOutput("err_pulse_end", DW'(tx_err_o), DW'(0));
    for (int i = 0; i < 4; i++) begin
      checkOutput("clear_no_req", DW'(br_req_o), DW'(0));
      tick();
    end

    $display("[TB] RX backpressure with depth 2");
    routerSend(mkMsg(BR_SVC_TGT, ADDR, 32'h5000_0001));
    routerSend(mkMsg(BR_SVC_CLEAR, ADDR, 32'h5000_0002));
    checkOutput("rx_valid_full", DW'(rx_valid_o), DW'(1));
    f = mkMsg(BR_SVC_ALL, 16'hFFFF, 32'h5000_0003);
    br_flit_i = f;
    br_req_i = 1'b1;
    rxExp.push_back(f);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("rx_full_no_ack", DW'(br_ack_o), DW'(0));
    end
    rx_ready_i = 1'b1;
    tick();
    rx_ready_i = 1'b0;
    for (int i = 0; i < 10 && !br_ack_o; i++) tick();
    checkOutput("rx_ack_after_pop", DW'(br_ack_o), DW'(1));
    br_req_i = 1'b0;
    tick();
    rx_ready_i = 1'b1;
    for (int i = 0; i < 10 && rx_valid_o; i++) tick();
    rx_ready_i = 1'b0;
    checkOutput("rx_drained", DW'(rxExp.size()), DW'(0));

    $display("[TB] long RX req");
    f = mkMsg(BR_SVC_MON, 16'h0001, 32'h6000_0006);
    br_flit_i = f;
    br_req_i = 1'b1;
    rxExp.push_back(f);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("long_req_ack", DW'(br_ack_o), DW'(1));
    end
    br_req_i = 1'b0;
    #1;
    checkOutput("ack_before_fall_edge", DW'(br_ack_o), DW'(1));
    tick();
    checkOutput("ack_after_fall", DW'(br_ack_o), DW'(0));
    checkOutput("long_req_valid", DW'(rx_valid_o), DW'(1));
    rx_ready_i = 1'b1;
    tick();
    rx_ready_i = 1'b0;
    checkOutput("long_req_single_push", DW'(rx_valid_o), DW'(0));
    checkOutput("rx_queue_empty", DW'(rxExp.size()), DW'(0));
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
